// File: rtl/fetch_stage.sv
// Instruction fetch stage and IF/ID register: PC, req/done fetch handshake,
// one-entry stall skid buffer and EX redirects. Optional macro: FETCH_ALIGN_CHECK_EN.
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_done,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc_plus2,
    output logic        if_valid,
    output logic        if_err
);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic        pend_q, pend_d;
    logic [15:0] pend_addr_q, pend_addr_d;
    logic        skid_v_q, skid_v_d;
    logic [15:0] skid_instr_q, skid_instr_d;
    logic [15:0] skid_pc2_q, skid_pc2_d;
    logic [15:0] if_instr_q, if_instr_d;
    logic [15:0] if_pc2_q, if_pc2_d;
    logic        if_valid_q, if_valid_d;
    logic        if_err_q, if_err_d;

    logic [15:0] pc_plus2;
    logic [15:0] fetch_addr;
    logic        pc_odd;
    logic        can_fetch;
    logic        issue;
    logic        misalign;
    logic        fire;

    assign pc_plus2 = pc_q + 16'd2;

`ifdef FETCH_ALIGN_CHECK_EN
    assign pc_odd     = pc_q[0];
    assign fetch_addr = pc_q;
`else
    assign pc_odd     = 1'b0;
    assign fetch_addr = {pc_q[15:1], 1'b0};
`endif

    // A new fetch is never started in a cycle that redirects or halts.
    assign can_fetch = (state_q == ST_RUN) && !pend_q && !stall && !redirect && !halt;
    assign issue     = can_fetch && !pc_odd;
    assign misalign  = can_fetch && pc_odd && !skid_v_q;
    assign fire      = imem_req && imem_done;

    // NOTE: reset here is synchronous, so it lives inside the clocked block;
    // all sequential state uses non-blocking assignments.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_RUN;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (redirect) begin
                    if (pend_q && !imem_done) state_d = ST_DRAIN;
                end else if (halt || misalign) begin
                    state_d = ST_HALTED;
                end
            end
            ST_DRAIN: begin
                if (halt && !redirect) state_d = ST_HALTED;
                else if (imem_done)    state_d = ST_RUN;
            end
            default: state_d = ST_HALTED;
        endcase
    end

    // Request outputs: an outstanding request keeps its original address.
    always_comb begin
        imem_req  = rst_n && (pend_q || issue);
        imem_addr = pend_q ? pend_addr_q : fetch_addr;
    end

    always_comb begin
        // NOTE: every target gets a hold default first so no latches are inferred.
        pc_d         = pc_q;
        pend_d       = pend_q;
        pend_addr_d  = pend_addr_q;
        skid_v_d     = skid_v_q;
        skid_instr_d = skid_instr_q;
        skid_pc2_d   = skid_pc2_q;
        if_instr_d   = if_instr_q;
        if_pc2_d     = if_pc2_q;
        if_valid_d   = if_valid_q;
        if_err_d     = if_err_q;

        if (issue) begin
            pend_d      = 1'b1;
            pend_addr_d = fetch_addr;
        end
        if (fire) pend_d = 1'b0;

        if (state_q != ST_HALTED && (redirect || halt)) begin
            if (redirect) pc_d = redirect_pc;
            skid_v_d   = 1'b0;
            if_instr_d = NOP_INSTR;
            if_pc2_d   = 16'h0000;
            if_valid_d = 1'b0;
            if_err_d   = 1'b0;
        end else if (state_q == ST_RUN) begin
            if (misalign) begin
                if_instr_d = NOP_INSTR;
                if_pc2_d   = pc_plus2;
                if_valid_d = 1'b1;
                if_err_d   = 1'b1;
            end else if (!stall) begin
                if_err_d = 1'b0;
                if (skid_v_q) begin
                    // Releasing the skid while a zero-latency fetch lands refills it.
                    if_instr_d   = skid_instr_q;
                    if_pc2_d     = skid_pc2_q;
                    if_valid_d   = 1'b1;
                    skid_v_d     = fire;
                    skid_instr_d = imem_rdata;
                    skid_pc2_d   = pc_plus2;
                end else if (fire) begin
                    if_instr_d = imem_rdata;
                    if_pc2_d   = pc_plus2;
                    if_valid_d = 1'b1;
                end else begin
                    if_instr_d = NOP_INSTR;
                    if_pc2_d   = 16'h0000;
                    if_valid_d = 1'b0;
                end
            end else if (fire) begin
                skid_v_d     = 1'b1;
                skid_instr_d = imem_rdata;
                skid_pc2_d   = pc_plus2;
            end
            if (fire) pc_d = pc_plus2;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            pend_q       <= 1'b0;
            pend_addr_q  <= 16'h0000;
            skid_v_q     <= 1'b0;
            skid_instr_q <= NOP_INSTR;
            skid_pc2_q   <= 16'h0000;
            if_instr_q   <= NOP_INSTR;
            if_pc2_q     <= 16'h0000;
            if_valid_q   <= 1'b0;
            if_err_q     <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            pend_q       <= pend_d;
            pend_addr_q  <= pend_addr_d;
            skid_v_q     <= skid_v_d;
            skid_instr_q <= skid_instr_d;
            skid_pc2_q   <= skid_pc2_d;
            if_instr_q   <= if_instr_d;
            if_pc2_q     <= if_pc2_d;
            if_valid_q   <= if_valid_d;
            if_err_q     <= if_err_d;
        end
    end

    assign if_instr    = if_instr_q;
    assign if_pc_plus2 = if_pc2_q;
    assign if_valid    = if_valid_q;
    assign if_err      = if_err_q;

endmodule
